// File: rtl/spb_pkg.sv
// Shared SPB definitions: bus widths, arbiter state encoding, wait-counter width
// and the request/response bundles used inside the arbiter.
package spb_pkg;

  localparam int SPB_AW = 32;
  localparam int SPB_DW = 32;
  localparam int SPB_SW = 4;
  localparam int CNT_W  = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [SPB_SW-1:0] wstb;
    logic [SPB_AW-1:0] addr;
    logic [SPB_DW-1:0] wdata;
  } spb_req_t;

  typedef struct packed {
    logic              ready;
    logic [SPB_DW-1:0] rdata;
    logic              excpt;
  } spb_rsp_t;

endpackage

// File: rtl/spb_timeout.sv
// Saturating stall counter for one grant; flags the cycle where the
// wait reaches limit-1. A limit of zero never expires.
module spb_timeout
  import spb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  // count stalled grant cycles, held at zero outside a grant, never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_q <= '0;
    else if (clear)                   cnt_q <= '0;
    else if (enable && cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
  end

  assign expired = (limit != '0) && (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/spb_arb.sv
// Two-requester SPB arbiter (S0 = fetch, S1 = data) onto one downstream port.
// One-cycle arbitration in IDLE, combinational pass-through while granted,
// one bubble between grants, optional wait timeout that answers with an exception.
module spb_arb
  import spb_pkg::*;
#(
  parameter int PRIO_MODE = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        S0_SPB_VALID,
  input  logic [3:0]  S0_SPB_WSTB,
  input  logic [31:0] S0_SPB_ADDR,
  input  logic [31:0] S0_SPB_WDATA,
  output logic        S0_SPB_READY,
  output logic [31:0] S0_SPB_RDATA,
  output logic        S0_SPB_EXCPT,
  input  logic        S1_SPB_VALID,
  input  logic [3:0]  S1_SPB_WSTB,
  input  logic [31:0] S1_SPB_ADDR,
  input  logic [31:0] S1_SPB_WDATA,
  output logic        S1_SPB_READY,
  output logic [31:0] S1_SPB_RDATA,
  output logic        S1_SPB_EXCPT,
  output logic        M_SPB_VALID,
  output logic [3:0]  M_SPB_WSTB,
  output logic [31:0] M_SPB_ADDR,
  output logic [31:0] M_SPB_WDATA,
  input  logic        M_SPB_READY,
  input  logic [31:0] M_SPB_RDATA,
  input  logic        M_SPB_EXCPT
);

  spb_req_t   s0_req, s1_req, sel_req, m_req;
  spb_rsp_t   gnt_rsp, s0_rsp, s1_rsp;
  logic [1:0] state_q, state_d;
  logic       last_q;     // 1: S1 was granted last
  logic       in_gnt, sel1, any_vld, pick1, expired, tmo_hit;

  assign s0_req  = {S0_SPB_VALID, S0_SPB_WSTB, S0_SPB_ADDR, S0_SPB_WDATA};
  assign s1_req  = {S1_SPB_VALID, S1_SPB_WSTB, S1_SPB_ADDR, S1_SPB_WDATA};
  assign in_gnt  = (state_q == GNT0) || (state_q == GNT1);
  assign sel1    = (state_q == GNT1);
  assign sel_req = sel1 ? s1_req : s0_req;
  assign any_vld = S0_SPB_VALID || S1_SPB_VALID;

  // S1 wins alone, always in fixed mode, or on a tie when S0 was last granted
  assign pick1 = S1_SPB_VALID &&
                 ((PRIO_MODE == 0) || !S0_SPB_VALID || !last_q);

  spb_timeout u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clear   (!in_gnt),
    .enable  (in_gnt && !M_SPB_READY),
    .limit   (CNT_W'(TIMEOUT)),
    .expired (expired)
  );

  // a real completion in the limit cycle beats the timeout
  assign tmo_hit = in_gnt && sel_req.valid && !M_SPB_READY && expired;

  // next state: grant from IDLE, drop back on completion, timeout or withdrawn request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (any_vld) state_d = pick1 ? GNT1 : GNT0;
      GNT0, GNT1: if (!sel_req.valid || M_SPB_READY || tmo_hit) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // state and last-grant registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_vld) last_q <= pick1;
    end
  end

  // granted datapath; everything is zero in IDLE
  always_comb begin
    m_req   = '0;
    gnt_rsp = '0;
    if (in_gnt) begin
      m_req       = sel_req;
      m_req.valid = sel_req.valid && !tmo_hit;
      if (tmo_hit) begin
        gnt_rsp.ready = 1'b1;
        gnt_rsp.excpt = 1'b1;
      end else begin
        gnt_rsp.ready = M_SPB_READY && sel_req.valid;
        gnt_rsp.rdata = M_SPB_RDATA;
        gnt_rsp.excpt = M_SPB_EXCPT;
      end
    end
  end

  assign s0_rsp = (state_q == GNT0) ? gnt_rsp : '0;
  assign s1_rsp = sel1 ? gnt_rsp : '0;

  assign {M_SPB_VALID, M_SPB_WSTB, M_SPB_ADDR, M_SPB_WDATA} = m_req;
  assign {S0_SPB_READY, S0_SPB_RDATA, S0_SPB_EXCPT}         = s0_rsp;
  assign {S1_SPB_READY, S1_SPB_RDATA, S1_SPB_EXCPT}         = s1_rsp;

endmodule
